// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT datapath: default word width, complex
// field helpers, output saturation and the 16-point twiddle constants.
package fft_pkg;

  localparam int FFT_WIDTH = 36;

  // Words are handled through a 64-bit carrier so the helpers serve any even
  // WIDTH up to 64; callers size-cast the result back to their half width.
  function automatic logic signed [63:0] fft_re(input logic [63:0] word, input int width);
    logic signed [63:0] t;
    int                 h;
    h = width / 2;
    t = signed'(word << (64 - width));
    return t >>> (64 - h);
  endfunction

  function automatic logic signed [63:0] fft_im(input logic [63:0] word, input int width);
    logic signed [63:0] t;
    int                 h;
    h = width / 2;
    t = signed'(word << (64 - h));
    return t >>> (64 - h);
  endfunction

  function automatic logic signed [63:0] fft_sat(input logic signed [63:0] x, input int h);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (h - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (h - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // e^(-j*2*pi*k/16) in Q1.17; +1.0 is clipped to the largest positive code.
  function automatic logic [FFT_WIDTH-1:0] fft_w16(input logic [2:0] k);
    logic [FFT_WIDTH-1:0] r;
    case (k)
      3'd0:    r = {18'sd131071, 18'sd0};
      3'd1:    r = {18'sd121095, -18'sd50159};
      3'd2:    r = {18'sd92682, -18'sd92682};
      3'd3:    r = {18'sd50159, -18'sd121095};
      3'd4:    r = {18'sd0, 18'h20000};
      3'd5:    r = {-18'sd50159, -18'sd121095};
      3'd6:    r = {-18'sd92682, -18'sd92682};
      default: r = {-18'sd121095, -18'sd50159};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fft_butterfly_unit.sv
// Two-stage pipelined radix-2 DIT butterfly: registered full-precision
// products, then rounded W*B and saturated A +/- W*B.
module fft_butterfly_unit
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] w,
  output logic             out_valid,
  output logic [WIDTH-1:0] apwb,
  output logic [WIDTH-1:0] anwb
);

  localparam int H = WIDTH / 2;
  localparam int F = H - 1;
  localparam int P = 2 * H;
  localparam int S = P + 2;
  localparam int E = H + 3;
  localparam logic signed [S-1:0] RND = {{(S - F){1'b0}}, 1'b1, {(F - 1){1'b0}}};

  logic signed [H-1:0] br, bi, wr, wi;
  logic signed [P-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
  logic signed [P-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
  logic [WIDTH-1:0]    a_d, a_q;
  logic                v1_d, v1_q;

  always_comb begin
    br     = H'(fft_re(64'(b), WIDTH));
    bi     = H'(fft_im(64'(b), WIDTH));
    wr     = H'(fft_re(64'(w), WIDTH));
    wi     = H'(fft_im(64'(w), WIDTH));
    p_rr_d = P'(wr) * P'(br);
    p_ii_d = P'(wi) * P'(bi);
    p_ri_d = P'(wr) * P'(bi);
    p_ir_d = P'(wi) * P'(br);
    a_d    = a;
    v1_d   = in_valid;
    if (reset) begin
      p_rr_d = '0;
      p_ii_d = '0;
      p_ri_d = '0;
      p_ir_d = '0;
      a_d    = '0;
      v1_d   = 1'b0;
    end
  end

  logic signed [H-1:0] ar, ai;
  logic signed [S-1:0] sum_r, sum_i;
  logic signed [E-1:0] wbr, wbi, ar_e, ai_e, pr, pi, nr, ni;
  logic [WIDTH-1:0]    apwb_d, apwb_q, anwb_d, anwb_q;
  logic                v2_d, v2_q;

  // Sum at full precision, then one arithmetic shift gives round-half-up.
  always_comb begin
    ar     = H'(fft_re(64'(a_q), WIDTH));
    ai     = H'(fft_im(64'(a_q), WIDTH));
    sum_r  = S'(p_rr_q) - S'(p_ii_q) + RND;
    sum_i  = S'(p_ri_q) + S'(p_ir_q) + RND;
    wbr    = E'(sum_r >>> F);
    wbi    = E'(sum_i >>> F);
    ar_e   = E'(ar);
    ai_e   = E'(ai);
    pr     = ar_e + wbr;
    pi     = ai_e + wbi;
    nr     = ar_e - wbr;
    ni     = ai_e - wbi;
    apwb_d = {H'(fft_sat(64'(pr), H)), H'(fft_sat(64'(pi), H))};
    anwb_d = {H'(fft_sat(64'(nr), H)), H'(fft_sat(64'(ni), H))};
    v2_d   = v1_q;
    if (reset) begin
      apwb_d = '0;
      anwb_d = '0;
      v2_d   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    p_rr_q <= p_rr_d;
    p_ii_q <= p_ii_d;
    p_ri_q <= p_ri_d;
    p_ir_q <= p_ir_d;
    a_q    <= a_d;
    v1_q   <= v1_d;
    apwb_q <= apwb_d;
    anwb_q <= anwb_d;
    v2_q   <= v2_d;
  end

  assign out_valid = v2_q;
  assign apwb      = apwb_q;
  assign anwb      = anwb_q;

endmodule

// File: tb/tb_fft_butterfly_unit.sv
// Self-checking bench for fft_butterfly_unit: directed corner cases plus a
// randomized stream compared against an integer reference model.
module tb_fft_butterfly_unit;
  import fft_pkg::*;

  localparam int W = 36;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] a, b, w;
  logic         out_valid;
  logic [W-1:0] apwb, anwb;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic         v;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] w;
  } samp_t;

  always #5 clock = ~clock;

  fft_butterfly_unit #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .w         (w),
    .out_valid (out_valid),
    .apwb      (apwb),
    .anwb      (anwb)
  );

  function automatic logic [W-1:0] cpack(input longint re, input longint im);
    logic [W-1:0] r;
    r[35:18] = re[17:0];
    r[17:0]  = im[17:0];
    return r;
  endfunction

  function automatic longint re_of(input logic [W-1:0] x);
    return longint'($signed(x[35:18]));
  endfunction

  function automatic longint im_of(input logic [W-1:0] x);
    return longint'($signed(x[17:0]));
  endfunction

  function automatic longint clamp(input longint x);
    if (x > 131071) return 131071;
    if (x < -131072) return -131072;
    return x;
  endfunction

  // Reference: exact integer products, +2^16 then floor-divide by 2^17.
  function automatic void bfly(input logic [W-1:0] av, bv, wv,
                               output logic [W-1:0] p, n);
    longint wbr, wbi;
    wbr = (re_of(wv) * re_of(bv) - im_of(wv) * im_of(bv) + 65536) >>> 17;
    wbi = (re_of(wv) * im_of(bv) + im_of(wv) * re_of(bv) + 65536) >>> 17;
    p = cpack(clamp(re_of(av) + wbr), clamp(im_of(av) + wbi));
    n = cpack(clamp(re_of(av) - wbr), clamp(im_of(av) - wbi));
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply(input logic [W-1:0] av, bv, wv);
    a = av;
    b = bv;
    w = wv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    a = cpack(1000, -2000);
    b = cpack(300, 400);
    w = cpack(131071, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        reset = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        w = '0;
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_valid cycle %0d got %b expected 0", i, out_valid);
      end
      checks++;
      if (apwb !== '0) begin
        failures++;
        $display("FAIL reset_apwb cycle %0d got %h expected 0", i, apwb);
      end
      checks++;
      if (anwb !== '0) begin
        failures++;
        $display("FAIL reset_anwb cycle %0d got %h expected 0", i, anwb);
      end
    end
  endtask

  task automatic test_identity();
    apply(cpack(1000, -2000), cpack(300, 400), cpack(131071, 0));
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL identity_valid got %b expected 1", out_valid);
    end
    checks++;
    if (apwb !== cpack(1300, -1600)) begin
      failures++;
      $display("FAIL identity_apwb got (%0d,%0d) expected (1300,-1600)", re_of(apwb), im_of(apwb));
    end
    checks++;
    if (anwb !== cpack(700, -2400)) begin
      failures++;
      $display("FAIL identity_anwb got (%0d,%0d) expected (700,-2400)", re_of(anwb), im_of(anwb));
    end
  endtask

  task automatic test_neg_j();
    apply(cpack(1000, -2000), cpack(300, 400), cpack(0, -131072));
    checks++;
    if (apwb !== cpack(1400, -2300)) begin
      failures++;
      $display("FAIL neg_j_apwb got (%0d,%0d) expected (1400,-2300)", re_of(apwb), im_of(apwb));
    end
    checks++;
    if (anwb !== cpack(600, -1700)) begin
      failures++;
      $display("FAIL neg_j_anwb got (%0d,%0d) expected (600,-1700)", re_of(anwb), im_of(anwb));
    end
  endtask

  task automatic test_rounding();
    apply(cpack(0, 0), cpack(1, -1), cpack(65536, 0));
    checks++;
    if (apwb !== cpack(1, 0)) begin
      failures++;
      $display("FAIL round_apwb got (%0d,%0d) expected (1,0)", re_of(apwb), im_of(apwb));
    end
    checks++;
    if (anwb !== cpack(-1, 0)) begin
      failures++;
      $display("FAIL round_anwb got (%0d,%0d) expected (-1,0)", re_of(anwb), im_of(anwb));
    end
  endtask

  task automatic test_saturation();
    apply(cpack(131071, 0), cpack(131071, 0), cpack(131071, 0));
    checks++;
    if (apwb !== cpack(131071, 0)) begin
      failures++;
      $display("FAIL sat_pos_apwb got (%0d,%0d) expected (131071,0)", re_of(apwb), im_of(apwb));
    end
    checks++;
    if (anwb !== cpack(1, 0)) begin
      failures++;
      $display("FAIL sat_pos_anwb got (%0d,%0d) expected (1,0)", re_of(anwb), im_of(anwb));
    end
    apply(cpack(-131072, 0), cpack(-131072, 0), cpack(0, -131072));
    checks++;
    if (apwb !== cpack(-131072, 131071)) begin
      failures++;
      $display("FAIL sat_neg_apwb got (%0d,%0d) expected (-131072,131071)", re_of(apwb), im_of(apwb));
    end
    checks++;
    if (anwb !== cpack(-131072, -131072)) begin
      failures++;
      $display("FAIL sat_neg_anwb got (%0d,%0d) expected (-131072,-131072)", re_of(anwb), im_of(anwb));
    end
  endtask

  task automatic test_twiddles();
    logic [W-1:0] av, bv, wv, ep, en;
    for (int k = 0; k < 8; k++) begin
      av = rnd_word();
      bv = rnd_word();
      wv = fft_w16(3'(k));
      apply(av, bv, wv);
      bfly(av, bv, wv, ep, en);
      checks++;
      if (out_valid !== 1'b1) begin
        failures++;
        $display("FAIL twiddle_valid k=%0d got %b expected 1", k, out_valid);
      end
      checks++;
      if (apwb !== ep) begin
        failures++;
        $display("FAIL twiddle_apwb k=%0d got %h expected %h", k, apwb, ep);
      end
      checks++;
      if (anwb !== en) begin
        failures++;
        $display("FAIL twiddle_anwb k=%0d got %h expected %h", k, anwb, en);
      end
    end
  endtask

  // Model the pipeline as a two-deep queue of samples; reset empties it.
  task automatic test_back_to_back();
    samp_t        q[$];
    samp_t        s, z;
    logic [W-1:0] ep, en;
    z = '{v: 1'b0, a: '0, b: '0, w: '0};
    s = '{v: in_valid, a: a, b: b, w: w};
    q = '{z, s};
    for (int i = 0; i < 24; i++) begin
      reset = (i == 10);
      in_valid = (i == 9 || i == 10) ? 1'b1 : 1'($urandom_range(0, 1));
      a = rnd_word();
      b = rnd_word();
      w = rnd_word();
      step();
      if (reset) begin
        q = '{z, z};
      end else begin
        s = '{v: in_valid, a: a, b: b, w: w};
        q.push_back(s);
        void'(q.pop_front());
      end
      bfly(q[0].a, q[0].b, q[0].w, ep, en);
      checks++;
      if (out_valid !== q[0].v) begin
        failures++;
        $display("FAIL stream_valid cycle %0d got %b expected %b", i, out_valid, q[0].v);
      end
      checks++;
      if (apwb !== ep) begin
        failures++;
        $display("FAIL stream_apwb cycle %0d got %h expected %h", i, apwb, ep);
      end
      checks++;
      if (anwb !== en) begin
        failures++;
        $display("FAIL stream_anwb cycle %0d got %h expected %h", i, anwb, en);
      end
    end
    reset = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    w = '0;
    test_reset();
    test_identity();
    test_neg_j();
    test_rounding();
    test_saturation();
    test_twiddles();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
